// File: rtl/pulse_pkg.sv
// Shared constants and the parameter-set type for the pulse parameter loader.
// Used by the frame parser and by the shadow/stage/active register pipeline.
package pulse_pkg;

   localparam logic [7:0]  HDR_BYTE          = 8'hA5;
   localparam logic [7:0]  ADDR_PERIOD       = 8'h00;
   localparam logic [7:0]  ADDR_P1WIDTH      = 8'h01;
   localparam logic [7:0]  ADDR_DELAY        = 8'h02;
   localparam logic [7:0]  ADDR_P2WIDTH      = 8'h03;
   localparam logic [7:0]  ADDR_PBWIDTH      = 8'h04;
   localparam logic [7:0]  ADDR_OFFRES_DELAY = 8'h05;
   localparam logic [7:0]  ADDR_ATT_WAIT     = 8'h06;
   localparam logic [7:0]  ADDR_ATTEN        = 8'h07;
   localparam logic [7:0]  ADDR_FLAGS        = 8'h08;
   localparam logic [7:0]  ADDR_COMMIT       = 8'h7F;

   localparam logic [31:0] DEF_PERIOD_VAL    = 32'd200000;
   localparam logic [6:0]  ATT_MAX           = 7'h7F;

   typedef struct packed {
      logic [31:0] period;
      logic [31:0] p1width;
      logic [31:0] p2width;
      logic [31:0] delay;
      logic [31:0] pbwidth;
      logic [31:0] offres_delay;
      logic [31:0] att_wait;
      logic [31:0] p2start;
      logic [31:0] sync_up;
      logic [31:0] att_down;
      logic [6:0]  pp_pump;
      logic [6:0]  pp_probe;
      logic [6:0]  post_att;
      logic [7:0]  pulse_block;
      logic        pump;
      logic        double;
      logic        block;
   } pset_t;

   function automatic pset_t pset_default(input logic [31:0] per);
      pset_t p;
      p          = '0;
      p.period   = per;
      p.pp_pump  = ATT_MAX;
      p.pp_probe = ATT_MAX;
      p.post_att = ATT_MAX;
      return p;
   endfunction

endpackage

// File: rtl/frame_rx_fsm.sv
// Parses HDR/ADDR/D3..D0/CHK byte frames; emits a one-cycle write strobe the cycle after a good CHK.
// err pulses on a checksum mismatch or an inter-byte gap of TIMEOUT idle cycles mid-frame.
module frame_rx_fsm
   import pulse_pkg::*;
#(
   parameter int unsigned TIMEOUT = 2000000,
   parameter logic [7:0]  HDR     = HDR_BYTE
) (
   input  logic        clk_pll,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        wr_strobe,
   output logic [7:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic        err
);

   localparam int GW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_CHK} state_t;

   state_t        state, state_d;
   logic [1:0]    idx;
   logic [7:0]    addr_q, csum;
   logic [31:0]   data_q;
   logic [GW-1:0] gap_cnt;
   logic          timeout, chk_ok, chk_bad;

   always_comb begin
      state_d = state;
      chk_ok  = 1'b0;
      chk_bad = 1'b0;
      timeout = (state != S_IDLE) && !rx_valid && (gap_cnt == GW'(TIMEOUT - 1));
      if (timeout) begin
         state_d = S_IDLE;
      end else if (rx_valid) begin
         case (state)
            S_IDLE: if (rx_data == HDR) state_d = S_ADDR;
            S_ADDR: state_d = S_DATA;
            S_DATA: if (idx == 2'd3) state_d = S_CHK;
            S_CHK: begin
               state_d = S_IDLE;
               chk_ok  = (rx_data == csum);
               chk_bad = (rx_data != csum);
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_pll) begin
      if (reset) begin
         state     <= S_IDLE;
         idx       <= '0;
         addr_q    <= '0;
         csum      <= '0;
         data_q    <= '0;
         gap_cnt   <= '0;
         wr_strobe <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_d;
         wr_strobe <= chk_ok;
         err       <= chk_bad | timeout;
         // Gap counter only runs while a frame is in flight
         if (rx_valid || state == S_IDLE) gap_cnt <= '0;
         else                             gap_cnt <= gap_cnt + GW'(1);
         if (rx_valid && !timeout) begin
            if (state == S_ADDR) begin
               addr_q <= rx_data;
               csum   <= rx_data;
               idx    <= '0;
            end else if (state == S_DATA) begin
               data_q <= {data_q[23:0], rx_data};
               csum   <= csum ^ rx_data;
               idx    <= idx + 2'd1;
            end
         end
      end
   end

   assign wr_addr = addr_q;
   assign wr_data = data_q;

endmodule

// File: rtl/pulse_param_loader.sv
// Shadow registers fed by UART frames; a commit derives/checks timing (2 cycles) and stages the set.
// The staged set is applied atomically on the next cycle_start; outputs change only then or on reset.
module pulse_param_loader
   import pulse_pkg::*;
#(
   parameter int unsigned TIMEOUT    = 2000000,
   parameter logic [31:0] DEF_PERIOD = DEF_PERIOD_VAL,
   parameter logic [7:0]  HDR        = HDR_BYTE
) (
   input  logic        clk_pll,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        cycle_start,
   output logic [31:0] period,
   output logic [31:0] p1width,
   output logic [31:0] p2width,
   output logic [31:0] delay,
   output logic [31:0] pbwidth,
   output logic [31:0] offres_delay,
   output logic [31:0] p2start,
   output logic [31:0] sync_up,
   output logic [31:0] att_down,
   output logic [6:0]  pp_pump,
   output logic [6:0]  pp_probe,
   output logic [6:0]  post_att,
   output logic [7:0]  pulse_block,
   output logic        pump,
   output logic        double,
   output logic        block,
   output logic        pending,
   output logic        frame_err,
   output logic        applied
);

   logic        wr_strobe, rx_err;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;

   frame_rx_fsm #(.TIMEOUT(TIMEOUT), .HDR(HDR)) u_rx (
      .clk_pll   (clk_pll),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .err       (rx_err)
   );

   pset_t       sh, cset, stg, act;
   logic        calc_vld, calc_carry;
   logic [32:0] s1, s2, s3;
   logic        addr_ok, is_commit, reject, apply;

   always_comb begin
      s1 = {1'b0, sh.p1width} + {1'b0, sh.delay};
      s2 = {1'b0, s1[31:0]}   + {1'b0, sh.p2width};
      s3 = {1'b0, s2[31:0]}   + {1'b0, sh.att_wait};
      is_commit = (wr_addr == ADDR_COMMIT);
      addr_ok   = is_commit || (wr_addr <= ADDR_FLAGS);
      reject    = calc_carry || (cset.sync_up >= cset.period) || (cset.period == 32'd0);
      apply     = cycle_start && pending;
   end

   always_ff @(posedge clk_pll) begin
      if (reset) begin
         sh         <= pset_default(DEF_PERIOD);
         cset       <= pset_default(DEF_PERIOD);
         stg        <= pset_default(DEF_PERIOD);
         act        <= pset_default(DEF_PERIOD);
         calc_vld   <= 1'b0;
         calc_carry <= 1'b0;
         pending    <= 1'b0;
         frame_err  <= 1'b0;
         applied    <= 1'b0;
      end else begin
         calc_vld  <= wr_strobe && is_commit;
         applied   <= apply;
         frame_err <= rx_err || (wr_strobe && !addr_ok) || (calc_vld && reject);
         if (wr_strobe) begin
            case (wr_addr)
               ADDR_PERIOD:       sh.period       <= wr_data;
               ADDR_P1WIDTH:      sh.p1width      <= wr_data;
               ADDR_DELAY:        sh.delay        <= wr_data;
               ADDR_P2WIDTH:      sh.p2width      <= wr_data;
               ADDR_PBWIDTH:      sh.pbwidth      <= wr_data;
               ADDR_OFFRES_DELAY: sh.offres_delay <= wr_data;
               ADDR_ATT_WAIT:     sh.att_wait     <= wr_data;
               ADDR_ATTEN: begin
                  sh.pp_pump  <= wr_data[6:0];
                  sh.pp_probe <= wr_data[14:8];
                  sh.post_att <= wr_data[22:16];
               end
               ADDR_FLAGS: begin
                  sh.pulse_block <= wr_data[7:0];
                  sh.pump        <= wr_data[8];
                  sh.double      <= wr_data[9];
                  sh.block       <= wr_data[10];
               end
               ADDR_COMMIT: begin
                  // Snapshot here so later shadow writes cannot leak into this commit
                  cset          <= sh;
                  cset.p2start  <= s1[31:0];
                  cset.sync_up  <= s2[31:0];
                  cset.att_down <= s3[31:0];
                  calc_carry    <= s1[32] | s2[32] | s3[32];
               end
               default: ;
            endcase
         end
         if (apply) act <= stg;
         // A fresh stage taken in the same cycle as an apply keeps pending set
         if (calc_vld && !reject) begin
            stg     <= cset;
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end
      end
   end

   assign period       = act.period;
   assign p1width      = act.p1width;
   assign p2width      = act.p2width;
   assign delay        = act.delay;
   assign pbwidth      = act.pbwidth;
   assign offres_delay = act.offres_delay;
   assign p2start      = act.p2start;
   assign sync_up      = act.sync_up;
   assign att_down     = act.att_down;
   assign pp_pump      = act.pp_pump;
   assign pp_probe     = act.pp_probe;
   assign post_att     = act.post_att;
   assign pulse_block  = act.pulse_block;
   assign pump         = act.pump;
   assign double       = act.double;
   assign block        = act.block;

endmodule

// File: tb/tb_pulse_param_loader.sv
// Directed bench for pulse_param_loader: frames, commit checks, timeout, apply timing and reset.
module tb_pulse_param_loader;

   localparam int unsigned TMO = 64;

   logic        clk_pll = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        cycle_start = 1'b0;
   logic [31:0] period, p1width, p2width, delay, pbwidth, offres_delay;
   logic [31:0] p2start, sync_up, att_down;
   logic [6:0]  pp_pump, pp_probe, post_att;
   logic [7:0]  pulse_block;
   logic        pump, double, block, pending, frame_err, applied;

   int cmp = 0;
   int fails = 0;
   int err_cnt = 0;
   int app_cnt = 0;

   pulse_param_loader #(.TIMEOUT(TMO), .DEF_PERIOD(32'd200000), .HDR(8'hA5)) dut (
      .clk_pll(clk_pll), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .cycle_start(cycle_start), .period(period), .p1width(p1width), .p2width(p2width),
      .delay(delay), .pbwidth(pbwidth), .offres_delay(offres_delay), .p2start(p2start),
      .sync_up(sync_up), .att_down(att_down), .pp_pump(pp_pump), .pp_probe(pp_probe),
      .post_att(post_att), .pulse_block(pulse_block), .pump(pump), .double(double),
      .block(block), .pending(pending), .frame_err(frame_err), .applied(applied)
   );

   always #5 clk_pll = ~clk_pll;

   always @(negedge clk_pll) begin
      if (frame_err) err_cnt++;
      if (applied)   app_cnt++;
   end

   task automatic wait_cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk_pll);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk_pll);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk_pll);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input bit bad);
      logic [7:0] c;
      c = a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
      if (bad) c = c ^ 8'hFF;
      send_byte(8'hA5);
      send_byte(a);
      send_byte(d[31:24]);
      send_byte(d[23:16]);
      send_byte(d[15:8]);
      send_byte(d[7:0]);
      send_byte(c);
   endtask

   task automatic commit_wait();
      send_frame(8'h7F, 32'h0, 1'b0);
      wait_cyc(4);
   endtask

   task automatic pulse_cs();
      @(negedge clk_pll);
      cycle_start = 1'b1;
      @(negedge clk_pll);
      cycle_start = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk_pll);
      reset = 1'b1;
      wait_cyc(3);
      reset = 1'b0;
      wait_cyc(1);
   endtask

   task automatic test_reset();
      do_reset();
      cmp++; if (period !== 32'd200000) begin fails++; $display("FAIL reset_period got %0d want 200000", period); end
      cmp++; if (p1width !== 32'd0) begin fails++; $display("FAIL reset_p1width got %0d want 0", p1width); end
      cmp++; if (pp_pump !== 7'h7F || post_att !== 7'h7F) begin fails++; $display("FAIL reset_att got %h/%h want 7f/7f", pp_pump, post_att); end
      cmp++; if ({pending, frame_err, applied} !== 3'b000) begin fails++; $display("FAIL reset_status got %b want 000", {pending, frame_err, applied}); end
   endtask

   task automatic test_basic();
      send_frame(8'h00, 32'd1000, 1'b0);
      send_frame(8'h01, 32'd20, 1'b0);
      send_frame(8'h02, 32'd100, 1'b0);
      send_frame(8'h03, 32'd40, 1'b0);
      send_frame(8'h06, 32'd50, 1'b0);
      commit_wait();
      cmp++; if (pending !== 1'b1) begin fails++; $display("FAIL basic_pending got %b want 1", pending); end
      cmp++; if (period !== 32'd200000) begin fails++; $display("FAIL basic_hold got %0d want 200000", period); end
      pulse_cs();
      cmp++; if (applied !== 1'b1 || pending !== 1'b0) begin fails++; $display("FAIL basic_applied got %b%b want 10", applied, pending); end
      cmp++; if (period !== 32'd1000 || p2start !== 32'd120) begin fails++; $display("FAIL basic_per_p2s got %0d/%0d want 1000/120", period, p2start); end
      cmp++; if (sync_up !== 32'd160 || att_down !== 32'd210) begin fails++; $display("FAIL basic_sync_att got %0d/%0d want 160/210", sync_up, att_down); end
      wait_cyc(1);
      cmp++; if (applied !== 1'b0) begin fails++; $display("FAIL basic_applied_pulse got %b want 0", applied); end
   endtask

   task automatic test_bad_chk();
      int e0;
      e0 = err_cnt;
      send_frame(8'h01, 32'd77, 1'b1);
      wait_cyc(3);
      cmp++; if (err_cnt !== e0 + 1) begin fails++; $display("FAIL badchk_err got %0d want %0d", err_cnt, e0 + 1); end
      commit_wait();
      pulse_cs();
      cmp++; if (p1width !== 32'd20) begin fails++; $display("FAIL badchk_p1width got %0d want 20", p1width); end
      e0 = err_cnt;
      send_frame(8'h20, 32'd5, 1'b0);
      wait_cyc(3);
      cmp++; if (err_cnt !== e0 + 1) begin fails++; $display("FAIL badaddr_err got %0d want %0d", err_cnt, e0 + 1); end
   endtask

   task automatic test_reject();
      int e0, a0;
      send_frame(8'h00, 32'd100, 1'b0);
      send_frame(8'h01, 32'd60, 1'b0);
      send_frame(8'h02, 32'd30, 1'b0);
      send_frame(8'h03, 32'd20, 1'b0);
      e0 = err_cnt;
      commit_wait();
      cmp++; if (err_cnt !== e0 + 1) begin fails++; $display("FAIL reject_err got %0d want %0d", err_cnt, e0 + 1); end
      cmp++; if (pending !== 1'b0) begin fails++; $display("FAIL reject_pending got %b want 0", pending); end
      a0 = app_cnt;
      pulse_cs();
      wait_cyc(1);
      cmp++; if (app_cnt !== a0 || period !== 32'd1000) begin fails++; $display("FAIL reject_hold got %0d/%0d want %0d/1000", app_cnt, period, a0); end
   endtask

   task automatic test_timeout();
      int e0;
      e0 = err_cnt;
      send_byte(8'hA5);
      send_byte(8'h01);
      wait_cyc(TMO + 6);
      cmp++; if (err_cnt !== e0 + 1) begin fails++; $display("FAIL timeout_err got %0d want %0d", err_cnt, e0 + 1); end
      send_frame(8'h00, 32'd2000, 1'b0);
      commit_wait();
      pulse_cs();
      cmp++; if (period !== 32'd2000 || sync_up !== 32'd110) begin fails++; $display("FAIL timeout_recover got %0d/%0d want 2000/110", period, sync_up); end
   endtask

   task automatic test_hold_reset();
      int a0;
      send_frame(8'h00, 32'd3000, 1'b0);
      commit_wait();
      wait_cyc(10000);
      cmp++; if (pending !== 1'b1 || period !== 32'd2000) begin fails++; $display("FAIL hold_state got %b/%0d want 1/2000", pending, period); end
      do_reset();
      cmp++; if (pending !== 1'b0 || period !== 32'd200000) begin fails++; $display("FAIL hold_reset got %b/%0d want 0/200000", pending, period); end
      cmp++; if (pp_pump !== 7'h7F || pp_probe !== 7'h7F || post_att !== 7'h7F) begin fails++; $display("FAIL hold_reset_att got %h/%h/%h want 7f", pp_pump, pp_probe, post_att); end
      a0 = app_cnt;
      pulse_cs();
      wait_cyc(1);
      cmp++; if (app_cnt !== a0) begin fails++; $display("FAIL hold_discard got %0d want %0d", app_cnt, a0); end
   endtask

   task automatic test_atten();
      send_frame(8'h07, 32'h00123456, 1'b0);
      send_frame(8'h08, 32'h000005AB, 1'b0);
      commit_wait();
      pulse_cs();
      cmp++; if (pp_pump !== 7'd86 || pp_probe !== 7'd52 || post_att !== 7'd18) begin fails++; $display("FAIL atten got %0d/%0d/%0d want 86/52/18", pp_pump, pp_probe, post_att); end
      cmp++; if ({pulse_block, pump, double, block} !== {8'hAB, 3'b101}) begin fails++; $display("FAIL flags got %h %b%b%b want ab 101", pulse_block, pump, double, block); end
      cmp++; if (period !== 32'd200000) begin fails++; $display("FAIL atten_period got %0d want 200000", period); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_chk();
      test_reject();
      test_timeout();
      test_hold_reset();
      test_atten();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
      $finish;
   end

endmodule
